// File: rtl/contador_regressivo.sv
// Loadable two-stage cascaded down-counter with one-cycle expiry pulse.
// Optional periodic reload at expiry: define CONTADOR_REGRESSIVO_AUTO_RELOAD_EN.
module contador_regressivo #(
    parameter int LOW_MOD  = 12,
    parameter int HIGH_MOD = 11,
    parameter int W        = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_low,
    input  logic [W-1:0] load_high,
    input  logic         start,
    input  logic         pause,
    output logic [W-1:0] low_out,
    output logic [W-1:0] high_out,
    output logic         borrow,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [W-1:0] LOW_MAX  = W'(LOW_MOD - 1);
    localparam logic [W-1:0] HIGH_MAX = W'(HIGH_MOD - 1);

    state_t       state_q, state_d;
    logic [W-1:0] low_q, low_d;
    logic [W-1:0] high_q, high_d;
    logic [W-1:0] sat_low, sat_high;
    logic         at_zero;

`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
    logic [W-1:0] rld_low_q, rld_low_d;
    logic [W-1:0] rld_high_q, rld_high_d;
`endif

    always_comb begin
        sat_low  = (load_low  > LOW_MAX)  ? LOW_MAX  : load_low;
        sat_high = (load_high > HIGH_MAX) ? HIGH_MAX : load_high;
        at_zero  = (low_q == '0) && (high_q == '0);
    end

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        high_d  = high_q;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
        rld_low_d  = rld_low_q;
        rld_high_d = rld_high_q;
`endif
        if (load) begin
            state_d = IDLE;
            low_d   = sat_low;
            high_d  = sat_high;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
            rld_low_d  = sat_low;
            rld_high_d = sat_high;
`endif
        end else begin
            unique case (state_q)
                IDLE, PAUSED: begin
                    if (!pause && start) state_d = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (at_zero) begin
                        state_d = EXPIRED;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
                        low_d  = rld_low_q;
                        high_d = rld_high_q;
`endif
                    end else if (low_q == '0) begin
                        // low wraps and borrows from high
                        low_d  = LOW_MAX;
                        high_d = high_q - 1'b1;
                    end else begin
                        low_d = low_q - 1'b1;
                    end
                end
                EXPIRED: begin
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
                    state_d = pause ? PAUSED : RUN;
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            low_q   <= '0;
            high_q  <= '0;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
            rld_low_q  <= '0;
            rld_high_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            high_q  <= high_d;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
            rld_low_q  <= rld_low_d;
            rld_high_q <= rld_high_d;
`endif
        end
    end

    assign borrow    = (state_q == RUN) && !load && !pause && (low_q == '0) && (high_q != '0);
    assign busy      = (state_q == RUN) || (state_q == PAUSED);
    assign done      = (state_q == EXPIRED);
    assign state_out = state_q;
    assign low_out   = low_q;
    assign high_out  = high_q;

endmodule

// File: tb/tb_contador_regressivo.sv
// Self-checking bench for contador_regressivo: vector table, corner sequences,
// and randomized stimulus against a remaining-ticks arithmetic model.
module tb_contador_regressivo;

    localparam int LM = 12;
    localparam int HM = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic       load, start, pause;
    logic [3:0] load_low, load_high;
    logic [3:0] low_out, high_out;
    logic       borrow, busy, done;
    logic [1:0] state_out;

    contador_regressivo #(.LOW_MOD(LM), .HIGH_MOD(HM), .W(4)) dut (
        .clk(clk), .rst(rst), .load(load), .load_low(load_low), .load_high(load_high),
        .start(start), .pause(pause), .low_out(low_out), .high_out(high_out),
        .borrow(borrow), .busy(busy), .done(done), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int last_borrow = 0;

    // Model: mode 0 idle, 1 run, 2 paused, 3 expired; count kept as ticks remaining.
    int m_mode = 0;
    int m_total = 0;
    int m_reload = 0;

    typedef struct {
        int ld, ll, lh, st, ps;
        int es, el, eh, eb;
    } vec_t;
    vec_t tv[$];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v >= m) ? m - 1 : v;
    endfunction

    function automatic int model_borrow(input int ld, input int ps);
        return (m_mode == 1 && ld == 0 && ps == 0 && (m_total % LM) == 0 && m_total != 0) ? 1 : 0;
    endfunction

    task automatic model_update(input int ld, input int ll, input int lh, input int st, input int ps);
        if (ld != 0) begin
            m_total  = sat(lh, HM) * LM + sat(ll, LM);
            m_reload = m_total;
            m_mode   = 0;
        end else begin
            case (m_mode)
                0, 2: if (ps == 0 && st != 0) m_mode = 1;
                1: begin
                    if (ps != 0) m_mode = 2;
                    else if (m_total == 0) begin
                        m_mode = 3;
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
                        m_total = m_reload;
`endif
                    end else m_total = m_total - 1;
                end
                default: begin
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
                    m_mode = (ps != 0) ? 2 : 1;
`else
                    m_mode = 0;
`endif
                end
            endcase
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".state"}, int'(state_out), m_mode);
        check({tag, ".low"},   int'(low_out),   m_total % LM);
        check({tag, ".high"},  int'(high_out),  m_total / LM);
        check({tag, ".busy"},  int'(busy),      (m_mode == 1 || m_mode == 2) ? 1 : 0);
        check({tag, ".done"},  int'(done),      (m_mode == 3) ? 1 : 0);
    endtask

    task automatic drive(input int ld, input int ll, input int lh, input int st, input int ps);
        load      = ld[0];
        load_low  = ll[3:0];
        load_high = lh[3:0];
        start     = st[0];
        pause     = ps[0];
    endtask

    task automatic step(input string tag, input int ld, input int ll, input int lh, input int st, input int ps);
        drive(ld, ll, lh, st, ps);
        #1;
        last_borrow = int'(borrow);
        check({tag, ".borrow"}, last_borrow, model_borrow(ld, ps));
        @(posedge clk);
        model_update(ld, ll, lh, st, ps);
        #1;
        check_outputs(tag);
    endtask

    task automatic add(input int ld, input int ll, input int lh, input int st, input int ps,
                       input int es, input int el, input int eh, input int eb);
        vec_t v;
        v.ld = ld; v.ll = ll; v.lh = lh; v.st = st; v.ps = ps;
        v.es = es; v.el = el; v.eh = eh; v.eb = eb;
        tv.push_back(v);
    endtask

    initial begin
        int k;
        int borrows;
        int dones;

        // ld ll lh st ps | state low high borrow
        add(1, 15, 15, 0, 0,  0, 11, 10, 0);
        add(1, 12,  3, 0, 0,  0, 11,  3, 0);
        add(1, 11, 10, 0, 0,  0, 11, 10, 0);
        add(1,  2,  0, 0, 0,  0,  2,  0, 0);
        add(0,  0,  0, 1, 0,  1,  2,  0, 0);
        add(0,  0,  0, 0, 0,  1,  1,  0, 0);
        add(0,  0,  0, 0, 1,  2,  1,  0, 0);
        add(0,  0,  0, 1, 1,  2,  1,  0, 0);
        add(0,  0,  0, 0, 0,  2,  1,  0, 0);
        add(0,  0,  0, 1, 0,  1,  1,  0, 0);
        add(0,  0,  0, 0, 0,  1,  0,  0, 0);
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
        add(0,  0,  0, 0, 0,  3,  2,  0, 0);
        add(0,  0,  0, 1, 0,  1,  2,  0, 0);
        add(0,  0,  0, 0, 0,  1,  1,  0, 0);
`else
        add(0,  0,  0, 0, 0,  3,  0,  0, 0);
        add(0,  0,  0, 1, 0,  0,  0,  0, 0);
        add(0,  0,  0, 1, 0,  1,  0,  0, 0);
`endif
        add(1,  5,  0, 1, 1,  0,  5,  0, 0);
        add(0,  0,  0, 0, 0,  0,  5,  0, 0);
        add(1,  0,  1, 0, 0,  0,  0,  1, 0);
        add(0,  0,  0, 1, 0,  1,  0,  1, 0);
        add(0,  0,  0, 0, 0,  1, 11,  0, 1);
        add(0,  0,  0, 0, 1,  2, 11,  0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        #12;
        check_outputs("reset");
        check("reset.borrow", int'(borrow), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            drive(tv[i].ld, tv[i].ll, tv[i].lh, tv[i].st, tv[i].ps);
            #1;
            check($sformatf("row%0d.borrow", i), int'(borrow), tv[i].eb);
            @(posedge clk);
            model_update(tv[i].ld, tv[i].ll, tv[i].lh, tv[i].st, tv[i].ps);
            #1;
            check($sformatf("row%0d.state", i), int'(state_out), tv[i].es);
            check($sformatf("row%0d.low", i),   int'(low_out),   tv[i].el);
            check($sformatf("row%0d.high", i),  int'(high_out),  tv[i].eh);
            check($sformatf("row%0d.done", i),  int'(done),      (tv[i].es == 3) ? 1 : 0);
        end

        // 1:3 countdown: done must land 16 edges after the accepting edge
        step("l13", 1, 3, 1, 0, 0);
        step("l13", 0, 0, 0, 1, 0);
        k = 0;
        borrows = 0;
        while (k < 40) begin
            k++;
            step("l13", 0, 0, 0, 0, 0);
            borrows += last_borrow;
            if (done) break;
        end
        check("l13.done_latency", k, 16);
        check("l13.borrow_count", borrows, 1);
        step("l13_after", 0, 0, 0, 0, 0);
        check("l13.done_one_cycle", int'(done), 0);

        // asynchronous reset in the middle of a count
        step("rst", 1, 9, 0, 0, 0);
        step("rst", 0, 0, 0, 1, 0);
        step("rst", 0, 0, 0, 0, 0);
        step("rst", 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        m_mode = 0; m_total = 0; m_reload = 0;
        check_outputs("rst_async");
        #1 rst = 1'b0;
        step("rst_start", 0, 0, 0, 1, 0);
        step("rst_exp", 0, 0, 0, 0, 0);
        check("rst.done_pulse", int'(done), 1);
        step("rst_post", 0, 0, 0, 0, 0);

        // load on the edge where RUN would see 0:0 must suppress done
        step("ldz", 1, 1, 0, 0, 0);
        step("ldz", 0, 0, 0, 1, 0);
        step("ldz", 0, 0, 0, 0, 0);
        step("ldz", 1, 4, 0, 0, 0);
        check("ldz.no_done", int'(done), 0);
        step("ldz", 0, 0, 0, 0, 0);

        // periodic behaviour: count done pulses over 12 edges after start
        step("per", 1, 2, 0, 0, 0);
        step("per", 0, 0, 0, 1, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step("per", 0, 0, 0, 0, 0);
            dones += int'(done);
        end
`ifdef CONTADOR_REGRESSIVO_AUTO_RELOAD_EN
        check("per.done_count", dones, 3);
`else
        check("per.done_count", dones, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 15) == 0) ? 1 : 0,
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
